// File: rtl/fetch_entry_queue_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fetch_entry_queue_if                                                       |
// | Push (frontend) and fetch-entry (decode) handshake bundle for the queue.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
interface fetch_entry_queue_if #(
    parameter int DEPTH   = 4,
    parameter int ADDR_W  = 64,
    parameter int INSTR_W = 32
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic               flush_i;
    logic               push_valid_i;
    logic               push_ready_o;
    logic [ADDR_W-1:0]  push_addr_i;
    logic [INSTR_W-1:0] push_instr_i;
    logic               push_ex_valid_i;
    logic               fetch_entry_valid_o;
    logic               fetch_entry_ready_i;
    logic [ADDR_W-1:0]  fetch_entry_addr_o;
    logic [INSTR_W-1:0] fetch_entry_instr_o;
    logic               fetch_entry_ex_valid_o;
    logic [CNT_W-1:0]   count_o;

    modport slave (
        input  flush_i, push_valid_i, push_addr_i, push_instr_i, push_ex_valid_i,
               fetch_entry_ready_i,
        output push_ready_o, fetch_entry_valid_o, fetch_entry_addr_o,
               fetch_entry_instr_o, fetch_entry_ex_valid_o, count_o
    );

    modport master (
        output flush_i, push_valid_i, push_addr_i, push_instr_i, push_ex_valid_i,
               fetch_entry_ready_i,
        input  push_ready_o, fetch_entry_valid_o, fetch_entry_addr_o,
               fetch_entry_instr_o, fetch_entry_ex_valid_o, count_o
    );
endinterface
`default_nettype wire

// File: rtl/fetch_entry_queue.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fetch_entry_queue                                                          |
// | Small FIFO of fetched instructions feeding decode, with flush and a sticky |
// | exception stall that blocks new entries until the next flush.              |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module fetch_entry_queue #(
    parameter int DEPTH   = 4,
    parameter int ADDR_W  = 64,
    parameter int INSTR_W = 32
) (
    input  logic           clk_i,
    input  logic           rst_i,
    fetch_entry_queue_if.slave q
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [ADDR_W-1:0]  addr_mem  [DEPTH];
    logic [INSTR_W-1:0] instr_mem [DEPTH];
    logic               ex_mem    [DEPTH];

    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;
    logic             ex_stall;

    logic push_ready;
    logic head_valid;
    logic do_push;
    logic do_pop;

    // Ready is a function of registered state only, so decode backpressure
    // never reaches the frontend combinationally.
    always_comb begin
        push_ready = (count < FULL_CNT) && !ex_stall;
        head_valid = (count != '0);
        do_push    = q.push_valid_i && push_ready && !q.flush_i;
        do_pop     = head_valid && q.fetch_entry_ready_i && !q.flush_i;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                addr_mem[i]  <= '0;
                instr_mem[i] <= '0;
                ex_mem[i]    <= 1'b0;
            end
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            ex_stall <= 1'b0;
        end else if (q.flush_i) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            ex_stall <= 1'b0;
        end else begin
            if (do_push) begin
                addr_mem[wr_ptr]  <= q.push_addr_i;
                instr_mem[wr_ptr] <= q.push_instr_i;
                ex_mem[wr_ptr]    <= q.push_ex_valid_i;
                wr_ptr            <= wr_ptr + 1'b1;
                if (q.push_ex_valid_i) begin
                    ex_stall <= 1'b1;
                end
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign q.push_ready_o           = push_ready;
    assign q.fetch_entry_valid_o    = head_valid;
    assign q.fetch_entry_addr_o     = addr_mem[rd_ptr];
    assign q.fetch_entry_instr_o    = instr_mem[rd_ptr];
    assign q.fetch_entry_ex_valid_o = ex_mem[rd_ptr];
    assign q.count_o                = count;

endmodule
`default_nettype wire

// File: tb/tb_fetch_entry_queue.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_fetch_entry_queue                                                       |
// | Directed vector table plus hand sequences for wrap and reset.              |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_fetch_entry_queue;
    logic clk;
    logic rst;

    fetch_entry_queue_if #(.DEPTH(4), .ADDR_W(64), .INSTR_W(32)) bus ();

    fetch_entry_queue #(.DEPTH(4), .ADDR_W(64), .INSTR_W(32)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .q     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        flush;
        logic        pv;
        logic [63:0] addr;
        logic [31:0] instr;
        logic        ex;
        logic        rdy;
        logic        e_pr;
        logic        e_v;
        logic [63:0] e_addr;
        logic [31:0] e_instr;
        logic        e_ex;
        logic [2:0]  e_cnt;
        logic        pay;
    } vec_t;

    vec_t vecs[$];
    int   total = 0;
    int   bad   = 0;

    task automatic add(input logic flush, input logic pv, input logic [63:0] addr,
                       input logic [31:0] instr, input logic ex, input logic rdy,
                       input logic e_pr, input logic e_v, input logic [63:0] e_addr,
                       input logic [31:0] e_instr, input logic e_ex,
                       input logic [2:0] e_cnt, input logic pay);
        vec_t v;
        v.flush = flush; v.pv = pv; v.addr = addr; v.instr = instr; v.ex = ex;
        v.rdy = rdy; v.e_pr = e_pr; v.e_v = e_v; v.e_addr = e_addr;
        v.e_instr = e_instr; v.e_ex = e_ex; v.e_cnt = e_cnt; v.pay = pay;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic flush, input logic pv, input logic [63:0] addr,
                         input logic [31:0] instr, input logic ex, input logic rdy);
        bus.flush_i             = flush;
        bus.push_valid_i        = pv;
        bus.push_addr_i         = addr;
        bus.push_instr_i        = instr;
        bus.push_ex_valid_i     = ex;
        bus.fetch_entry_ready_i = rdy;
    endtask

    // Payload is only compared where the row asks for it; stale storage behind
    // an invalid head is otherwise unconstrained.
    task automatic check(input string name, input logic e_pr, input logic e_v,
                         input logic [63:0] e_addr, input logic [31:0] e_instr,
                         input logic e_ex, input logic [2:0] e_cnt, input logic pay);
        logic ok;
        total++;
        ok = (bus.push_ready_o === e_pr) && (bus.fetch_entry_valid_o === e_v) &&
             (bus.count_o === e_cnt);
        if (pay)
            ok = ok && (bus.fetch_entry_addr_o === e_addr) &&
                 (bus.fetch_entry_instr_o === e_instr) &&
                 (bus.fetch_entry_ex_valid_o === e_ex);
        if (!ok) begin
            bad++;
            $display("FAIL %s: got pr=%b v=%b cnt=%0d addr=%h instr=%h ex=%b; want pr=%b v=%b cnt=%0d addr=%h instr=%h ex=%b (payload checked=%b)",
                     name, bus.push_ready_o, bus.fetch_entry_valid_o, bus.count_o,
                     bus.fetch_entry_addr_o, bus.fetch_entry_instr_o,
                     bus.fetch_entry_ex_valid_o, e_pr, e_v, e_cnt, e_addr, e_instr,
                     e_ex, pay);
        end
    endtask

    initial begin
        // single push / pop
        add(0,1,64'h80000000,32'h13,0,1, 1,0,0,0,0,0,1);
        add(0,0,0,0,0,1,                 1,1,64'h80000000,32'h13,0,1,1);
        add(0,0,0,0,0,0,                 1,0,0,0,0,0,1);
        // fill with decode stalled, then full-with-pop
        add(0,1,64'h1000,32'hA1,0,0,     1,0,0,0,0,0,1);
        add(0,1,64'h1004,32'hA2,0,0,     1,1,64'h1000,32'hA1,0,1,1);
        add(0,1,64'h1008,32'hA3,0,0,     1,1,64'h1000,32'hA1,0,2,1);
        add(0,1,64'h100C,32'hA4,0,0,     1,1,64'h1000,32'hA1,0,3,1);
        add(0,1,64'h1010,32'hA5,0,0,     0,1,64'h1000,32'hA1,0,4,1);
        add(0,1,64'h1010,32'hA5,0,1,     0,1,64'h1000,32'hA1,0,4,1);
        add(0,1,64'h1010,32'hA5,0,1,     1,1,64'h1004,32'hA2,0,3,1);
        add(0,0,0,0,0,1,                 1,1,64'h1008,32'hA3,0,3,1);
        add(0,0,0,0,0,1,                 1,1,64'h100C,32'hA4,0,2,1);
        add(0,0,0,0,0,1,                 1,1,64'h1010,32'hA5,0,1,1);
        add(0,0,0,0,0,0,                 1,0,0,0,0,0,0);
        // exception stall
        add(0,1,64'h2000,32'hB0,0,0,     1,0,0,0,0,0,0);
        add(0,1,64'h2004,32'hB1,1,0,     1,1,64'h2000,32'hB0,0,1,1);
        add(0,1,64'h2008,32'hB2,0,0,     0,1,64'h2000,32'hB0,0,2,1);
        add(0,1,64'h2008,32'hB2,0,1,     0,1,64'h2000,32'hB0,0,2,1);
        add(0,1,64'h2008,32'hB2,0,1,     0,1,64'h2004,32'hB1,1,1,1);
        add(0,1,64'h2008,32'hB2,0,1,     0,0,0,0,0,0,0);
        add(1,1,64'h2008,32'hB2,0,1,     0,0,0,0,0,0,0);
        add(0,0,0,0,0,0,                 1,0,0,0,0,0,0);
        // flush with push and pop in the same cycle
        add(0,1,64'h3000,32'hC0,0,0,     1,0,0,0,0,0,0);
        add(0,1,64'h3004,32'hC1,0,0,     1,1,64'h3000,32'hC0,0,1,1);
        add(0,1,64'h3008,32'hC2,0,0,     1,1,64'h3000,32'hC0,0,2,1);
        add(1,1,64'h300C,32'hC3,0,1,     1,1,64'h3000,32'hC0,0,3,1);
        add(0,0,0,0,0,1,                 1,0,0,0,0,0,0);
        add(0,1,64'h4000,32'hD0,0,0,     1,0,0,0,0,0,0);
        add(0,0,0,0,0,0,                 1,1,64'h4000,32'hD0,0,1,1);
        add(0,0,0,0,0,1,                 1,1,64'h4000,32'hD0,0,1,1);

        rst = 1'b1;
        drive(0,0,0,0,0,0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            if (i != 0) @(negedge clk);
            drive(vecs[i].flush, vecs[i].pv, vecs[i].addr, vecs[i].instr,
                  vecs[i].ex, vecs[i].rdy);
            #1;
            check($sformatf("vec%0d", i), vecs[i].e_pr, vecs[i].e_v, vecs[i].e_addr,
                  vecs[i].e_instr, vecs[i].e_ex, vecs[i].e_cnt, vecs[i].pay);
        end

        // streamed push/pop pairs wrapping the pointers twice
        for (int k = 0; k <= 10; k++) begin
            @(negedge clk);
            drive(0, (k < 10), 64'h5000 + 64'(4 * k), 32'hE000 + 32'(k), 0, 1);
            #1;
            if (k == 0)
                check("wrap0", 1, 0, 0, 0, 0, 0, 0);
            else
                check($sformatf("wrap%0d", k), 1, 1, 64'h5000 + 64'(4 * (k - 1)),
                      32'hE000 + 32'(k - 1), 0, 1, 1);
        end

        // reset with entries queued and the exception stall pending
        @(negedge clk); drive(0,1,64'h6000,32'hF0,0,0); #1;
        check("rst_pre0", 1, 0, 0, 0, 0, 0, 0);
        @(negedge clk); drive(0,1,64'h6004,32'hF1,1,0); #1;
        check("rst_pre1", 1, 1, 64'h6000, 32'hF0, 0, 1, 1);
        @(negedge clk); rst = 1'b1; drive(0,1,64'h6008,32'hF2,0,1); #1;
        check("rst_pre2", 0, 1, 64'h6000, 32'hF0, 0, 2, 1);
        @(negedge clk); rst = 1'b0; drive(0,0,0,0,0,0); #1;
        check("rst_post", 1, 0, 0, 0, 0, 0, 1);
        @(negedge clk); drive(0,1,64'h7000,32'h77,0,0); #1;
        check("rst_store", 1, 0, 0, 0, 0, 0, 1);
        @(negedge clk); drive(0,0,0,0,0,0); #1;
        check("rst_push", 1, 1, 64'h7000, 32'h77, 0, 1, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
